// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared types and encodings for the serial system bus master/arbiter.
package sysbus_pkg;
  typedef enum logic [3:0] {
    IDLE, REQ, DEV, ACK_WAIT, MADDR, WDATA, RDATA, SPLIT_WAIT, DONE, ABORT
  } mstate_t;
  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;
  localparam logic [4:0] S1 = 5'b00001;
  localparam logic [4:0] S2 = 5'b00010;
  localparam logic [4:0] S3 = 5'b00100;
  localparam logic [4:0] BB = 5'b11111;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/master_port_ctrl_serial_shifter.sv
// serial_shifter: loadable shift register with MSB/LSB-first output and a last-bit flag.
// MSB-first values are expected left-aligned in load_val.
module serial_shifter #(
  parameter int W  = 12,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          msb_first,
  input  logic [W-1:0]  load_val,
  input  logic [CW-1:0] load_len,
  input  logic          shift,
  output logic          bit_out,
  output logic          last
);
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_d;
  logic          msb_q, msb_d;
  always_comb begin
    sh_d  = load ? load_val : shift ? (msb_q ? sh_q << 1 : sh_q >> 1) : sh_q;
    cnt_d = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
    len_d = load ? load_len : len_q;
    msb_d = load ? msb_first : msb_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      len_q <= '0;
      msb_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      msb_q <= msb_d;
    end
  end
  assign bit_out = msb_q ? sh_q[W-1] : sh_q[0];
  assign last    = cnt_q == len_q - 1'b1;
endmodule

// File: rtl/master_port_ctrl.sv
// master_port_ctrl: serial system-bus master sequencer; shifts device, address and data
// bits over the arbiter port with ack timeout, grant-loss abort and split/resume.
module master_port_ctrl
  import sysbus_pkg::*;
#(
  parameter int DEV_W       = 5,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [DEV_W-1:0]  req_dev,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              breq,
  input  logic              bgrant,
  output logic              mode,
  output logic              wr_bus,
  output logic              master_valid,
  input  logic              slave_ready,
  input  logic              rd_bus,
  input  logic              slave_valid,
  output logic              master_ready,
  input  logic              ack,
  input  logic              split
);
  localparam int SW = max4(DEV_W, ADDR_W, DATA_W, 1);
  localparam int CW = $clog2(max4(DEV_W, ADDR_W, DATA_W, ACK_TIMEOUT) + 1);
  mstate_t           state_q, state_d, resume_q, resume_d, nxt;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic [CW-1:0]     to_q, to_d, sh_len;
  logic [SW-1:0]     sh_val;
  logic              sh_load, sh_msb, sh_bit, sh_last, out_xfer, in_xfer, xfer;
  assign req_ready    = state_q == IDLE;
  assign breq         = state_q inside {REQ, DEV, ACK_WAIT, MADDR, WDATA, RDATA, SPLIT_WAIT};
  assign master_valid = state_q inside {DEV, MADDR, WDATA};
  assign master_ready = state_q == RDATA;
  assign rsp_valid    = state_q inside {DONE, ABORT};
  assign rsp_err      = state_q == ABORT;
  assign rsp_rdata    = rdata_q;
  assign mode         = mode_q;
  assign wr_bus       = sh_bit;
  assign out_xfer     = master_valid && slave_ready;
  assign in_xfer      = master_ready && slave_valid;
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    to_d     = to_q;
    nxt      = state_q;
    xfer     = 1'b0;
    sh_load  = 1'b0;
    sh_msb   = 1'b0;
    sh_val   = '0;
    sh_len   = CW'(DATA_W);
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = REQ;
        mode_d  = req_mode;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rbuf_d  = '0;
        sh_load = 1'b1;
        sh_msb  = 1'b1;
        sh_val  = SW'(req_dev) << (SW - DEV_W);
        sh_len  = CW'(DEV_W);
      end
      REQ: if (bgrant) state_d = DEV;
      DEV: begin
        if (!bgrant) state_d = ABORT;
        else if (out_xfer && sh_last) begin
          state_d = ACK_WAIT;
          to_d    = '0;
        end
      end
      ACK_WAIT: begin
        if (!bgrant) state_d = ABORT;
        else if (ack) begin
          state_d = MADDR;
          sh_load = 1'b1;
          sh_val  = SW'(addr_q);
          sh_len  = CW'(ADDR_W);
        end else if (to_q == CW'(ACK_TIMEOUT - 1)) state_d = ABORT;
        else to_d = to_q + 1'b1;
      end
      MADDR, WDATA, RDATA: begin
        xfer = (state_q == RDATA) ? in_xfer : out_xfer;
        if (state_q == RDATA && in_xfer) rbuf_d = DATA_W'({rd_bus, rbuf_q} >> 1);
        if (xfer && sh_last) begin
          nxt = DONE;
          if (state_q == MADDR) begin
            nxt     = (mode_q == MODE_WRITE) ? WDATA : RDATA;
            sh_load = 1'b1;
            sh_val  = SW'(wdata_q);
          end
        end
        // the phase a split interrupts is resumed at the bit it stopped on
        if (split && nxt != DONE) begin
          state_d  = SPLIT_WAIT;
          resume_d = nxt;
        end else state_d = bgrant ? nxt : ABORT;
      end
      SPLIT_WAIT: if (!split && bgrant) state_d = resume_q;
      DONE, ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) rdata_d = (mode_q == MODE_WRITE) ? '0 : rbuf_d;
    else if (state_d == ABORT) rdata_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
      mode_q   <= MODE_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
      to_q     <= to_d;
    end
  end
  serial_shifter #(.W(SW), .CW(CW)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .msb_first(sh_msb),
    .load_val (sh_val),
    .load_len (sh_len),
    .shift    (out_xfer || in_xfer),
    .bit_out  (sh_bit),
    .last     (sh_last)
  );
endmodule

// File: tb/tb_master_port_ctrl.sv
// tb_master_port_ctrl: directed scoreboard bench; stimulus pushes expected responses and
// serial bits, monitor process pops and compares on rsp_valid.
module tb_master_port_ctrl;
  import sysbus_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, req_mode, rsp_valid, rsp_err, breq, bgrant, mode;
  logic wr_bus, master_valid, slave_ready, rd_bus, slave_valid, master_ready, ack, split;
  logic [4:0] req_dev;
  logic [11:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  typedef struct {
    logic err;
    logic [7:0] rd;
    logic chk_rd;
    int lat;
    longint t_acc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic got_bits[$];
  logic exp_bits[$];
  int n_cmp = 0, n_fail = 0, mr_cnt = 0, rsp_total = 0;
  logic [7:0] rdv;
  always #5 clk = ~clk;
  master_port_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_dev(req_dev), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .breq(breq), .bgrant(bgrant), .mode(mode),
    .wr_bus(wr_bus), .master_valid(master_valid), .slave_ready(slave_ready), .rd_bus(rd_bus),
    .slave_valid(slave_valid), .master_ready(master_ready), .ack(ack), .split(split)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (master_valid && slave_ready) got_bits.push_back(wr_bus);
    if (master_ready) mr_cnt++;
    if (rsp_valid) begin
      rsp_total++;
      if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
      else begin
        e = sb.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("breq_at_rsp", 32'(breq), 32'(0));
        if (e.chk_rd) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
        if (e.lat != 0) chk("latency", 32'(($time - e.t_acc) / 10), 32'(e.lat));
      end
    end
  end
  task automatic check_idle_outputs(input string name);
    chk(name, 32'({breq, master_valid, master_ready, wr_bus, mode, rsp_valid, rsp_err, req_ready}), 32'(8'b0000_0001));
    chk({name, "_rdata"}, 32'(rsp_rdata), 32'(0));
  endtask
  task automatic issue(input logic m, input logic [4:0] d, input logic [11:0] a, input logic [7:0] w,
                       input logic err, input logic [7:0] rd, input logic crd, input int lat, input int nbits);
    @(posedge clk);
    #1;
    req_mode = m; req_dev = d; req_addr = a; req_wdata = w; req_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'(1));
    sb.push_back('{err, rd, crd, lat, longint'($time)});
    for (int i = 4; i >= 0; i--) exp_bits.push_back(d[i]);
    if (nbits >= 17) for (int i = 0; i < 12; i++) exp_bits.push_back(a[i]);
    if (nbits >= 25) for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic finish_txn(input int exp_mr);
    int bad;
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    #1;
    chk("rsp_timeout", 32'(sb.size()), 32'(0));
    chk("bit_count", 32'(got_bits.size()), 32'(exp_bits.size()));
    bad = 0;
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) if (got_bits[i] !== exp_bits[i]) bad++;
    chk("bit_seq", 32'(bad), 32'(0));
    chk("mready_cycles", 32'(mr_cnt), 32'(exp_mr));
    sb.delete(); got_bits.delete(); exp_bits.delete(); mr_cnt = 0;
  endtask
  task automatic wait_xfers(input int n);
    int c = 0;
    for (int k = 0; k < 200 && c < n; k++) begin
      @(negedge clk);
      if (master_valid && slave_ready) c++;
    end
    if (c < n) chk("xfer_timeout", 32'(c), 32'(n));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    req_valid = 0; req_mode = 0; req_dev = 0; req_addr = 0; req_wdata = 0;
    bgrant = 1; slave_ready = 1; rd_bus = 0; slave_valid = 0; ack = 1; split = 0;
    rdv = 8'hC3;
    #3 check_idle_outputs("reset");
    #20 rst = 1'b0;
    issue(MODE_WRITE, S2, 12'h0A5, 8'h5A, 1'b0, 8'h00, 1'b0, 28, 25);
    finish_txn(0);
    issue(MODE_READ, S3, 12'h003, 8'h00, 1'b0, 8'hC3, 1'b1, 45, 17);
    for (int k = 0; k < 100 && !master_ready; k++) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (2) begin
        @(posedge clk);
        #1 slave_valid = 1'b0;
      end
      @(posedge clk);
      #1 slave_valid = 1'b1; rd_bus = rdv[k];
    end
    @(posedge clk);
    #1 slave_valid = 1'b0;
    finish_txn(25);
    ack = 1'b0;
    issue(MODE_WRITE, S1, 12'h123, 8'hFF, 1'b1, 8'h00, 1'b1, 23, 5);
    finish_txn(0);
    ack = 1'b1;
    issue(MODE_WRITE, S1, 12'hFFF, 8'h81, 1'b0, 8'h00, 1'b0, 28, 25);
    finish_txn(0);
    issue(MODE_WRITE, S2, 12'h001, 8'hA5, 1'b0, 8'h00, 1'b0, 0, 25);
    wait_xfers(20);
    @(posedge clk);
    #1 split = 1'b1; slave_ready = 1'b0; bgrant = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("split_hold", 32'({breq, master_valid, master_ready}), 32'(3'b100));
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    split = 1'b0; bgrant = 1'b1; slave_ready = 1'b1;
    finish_txn(0);
    issue(MODE_WRITE, S3, 12'h0A5, 8'h3C, 1'b0, 8'h00, 1'b0, 28, 25);
    wait_xfers(9);
    #2 rst = 1'b1;
    #1 check_idle_outputs("async_reset");
    #2 rst = 1'b0;
    sb.delete(); got_bits.delete(); exp_bits.delete(); mr_cnt = 0;
    issue(MODE_WRITE, S1, 12'h0A5, 8'h3C, 1'b0, 8'h00, 1'b0, 28, 25);
    finish_txn(0);
    issue(MODE_WRITE, S2, 12'h055, 8'h0F, 1'b0, 8'h00, 1'b0, 28, 25);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b1; req_mode = MODE_READ; req_dev = BB; req_addr = 12'hABC; req_wdata = 8'hEE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    finish_txn(0);
    repeat (40) @(negedge clk);
    #1 chk("rsp_total", 32'(rsp_total), 32'(7));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
